// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator (rotation mode, gain uncompensated); CORDIC_QUADRANT_EN adds a +/-pi/2 pre-rotation at load.
// Latency: out_valid rises ITERATIONS edges after the accepting edge; one request in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready is low for the whole operation.
module cordic_rotator #(
    parameter int XY_WIDTH   = 16,
    parameter int Z_WIDTH    = 16,
    parameter int ITERATIONS = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XY_WIDTH-1:0] x_in,
    input  logic [XY_WIDTH-1:0] y_in,
    input  logic [Z_WIDTH-1:0]  z_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XY_WIDTH-1:0] x_out,
    output logic [XY_WIDTH-1:0] y_out,
    output logic [Z_WIDTH-1:0]  z_out
);

    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    // pi with 60 fractional bits
    localparam logic [127:0] PI_FX = 128'h3243F6A8885A308D;

    // atan(2^-n) by its power series in 60-bit fixed point, then scaled so pi -> 2^(Z_WIDTH-1)
    function automatic logic [Z_WIDTH-1:0] alpha_f(input int n);
        logic [127:0] acc;
        logic [127:0] term;
        int           sh;
        acc = '0;
        if (n == 0) begin
            acc = PI_FX >> 2;
        end else begin
            for (int k = 0; k < 64; k++) begin
                sh = 60 - n * (2 * k + 1);
                if (sh >= 0) begin
                    term = (128'd1 << sh) / 128'(2 * k + 1);
                    if (k % 2 == 0) acc = acc + term;
                    else            acc = acc - term;
                end
            end
        end
        acc = ((acc << (Z_WIDTH - 1)) + (PI_FX >> 1)) / PI_FX;
        return Z_WIDTH'(acc);
    endfunction

    logic [Z_WIDTH-1:0] alpha [ITERATIONS];
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_alpha
        localparam logic [Z_WIDTH-1:0] ALPHA_G = alpha_f(g);
        assign alpha[g] = ALPHA_G;
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]              iter;
    logic signed [XY_WIDTH-1:0] x_r, y_r, x_ld, y_ld;
    logic [Z_WIDTH-1:0]         z_r, z_ld;
    logic                       accept, rotate, last;

    assign last      = (iter == IW'(ITERATIONS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign x_out     = x_r;
    assign y_out     = y_r;
    assign z_out     = z_r;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rotate    = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                rotate = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_ld = x_in;
        y_ld = y_in;
        z_ld = z_in;
`ifdef CORDIC_QUADRANT_EN
        // angles beyond +/-pi/2 are folded back by an exact quarter turn
        case (z_in[Z_WIDTH-1:Z_WIDTH-2])
            2'b01: begin
                x_ld = -y_in;
                y_ld = x_in;
                z_ld = z_in - (Z_WIDTH'(1) << (Z_WIDTH - 2));
            end
            2'b10: begin
                x_ld = y_in;
                y_ld = -x_in;
                z_ld = z_in + (Z_WIDTH'(1) << (Z_WIDTH - 2));
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r  <= '0;
            y_r  <= '0;
            z_r  <= '0;
            iter <= '0;
        end else if (accept) begin
            x_r  <= x_ld;
            y_r  <= y_ld;
            z_r  <= z_ld;
            iter <= '0;
        end else if (rotate) begin
            if (z_r[Z_WIDTH-1]) begin
                x_r <= x_r + (y_r >>> iter);
                y_r <= y_r - (x_r >>> iter);
                z_r <= z_r + alpha[iter];
            end else begin
                x_r <= x_r - (y_r >>> iter);
                y_r <= y_r + (x_r >>> iter);
                z_r <= z_r - alpha[iter];
            end
            iter <= iter + 1'b1;
        end
    end

endmodule

// File: doc/cordic_rotator.md
CORDIC_ROTATOR -- requirements
Module: cordic_rotator

Interface
REQ-001 SHALL have parameter XY_WIDTH, default 16: signed width of x/y datapath.
REQ-002 SHALL have parameter Z_WIDTH, default 16: signed angle width; full scale ±pi maps to ±2^(Z_WIDTH-1).
REQ-003 SHALL have parameter ITERATIONS, default 14: micro-rotations per operation; legal range 1..XY_WIDTH-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 x_in, y_in  input  XY_WIDTH each  signed start vector.
REQ-009 z_in  input  Z_WIDTH  signed rotation angle.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 x_out, y_out  output  XY_WIDTH each  signed rotated vector, CORDIC gain uncompensated.
REQ-013 z_out  output  Z_WIDTH  signed residual angle.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), both registered-state decodes.
REQ-015 IDLE: accept on in_valid&&in_ready edge; load x,y,z registers (after optional pre-rotation, REQ-027); clear iteration counter i; go to RUN.
REQ-016 RUN: per edge, one micro-rotation: d = z[MSB]; d=1 -> x+=y>>>i, y-=x>>>i, z+=alpha_i; d=0 -> x-=y>>>i, y+=x>>>i, z-=alpha_i; shifts arithmetic, using pre-edge x,y.
REQ-017 alpha_i SHALL be a constant table: round(atan(2^-i)*2^(Z_WIDTH-1)/pi), i=0..ITERATIONS-1, computed at elaboration.
REQ-018 Counter i SHALL increment per RUN edge; edge with i==ITERATIONS-1 performs last rotation and moves to DONE.
REQ-019 Latency: out_valid SHALL rise on the ITERATIONS-th rising edge after the accepting edge.
REQ-020 DONE: outputs held stable until out_valid&&out_ready edge, then IDLE; in_ready returns high the cycle after.
REQ-021 in_valid while not in IDLE SHALL be ignored (no accept, no state change).
REQ-022 Adds/subtracts SHALL wrap two's-complement at XY_WIDTH/Z_WIDTH; no saturation. Caller keeps |x|,|y| <= 2^(XY_WIDTH-1)/2.33 to avoid overflow.
REQ-023 x_out/y_out/z_out SHALL be the x/y/z registers directly (no output mux delay).

Reset
REQ-024 rst high SHALL force state IDLE, i=0, x/y/z registers 0, hence x_out=y_out=z_out=0, out_valid=0, in_ready=1, immediately (asynchronously).
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the operation; no result emitted after deassertion.
REQ-026 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro CORDIC_QUADRANT_EN defined: at load, z_in[Z_WIDTH-1:Z_WIDTH-2]==01 -> load (x,y,z)=(-y_in, x_in, z_in-2^(Z_WIDTH-2)); ==10 -> (y_in, -x_in, z_in+2^(Z_WIDTH-2)); else unchanged; full ±pi range converges.
REQ-028 Macro undefined: load unchanged inputs; results defined only for |z_in| <= 2^(Z_WIDTH-2) (±pi/2); latency identical either way.

Verification (XY_WIDTH=Z_WIDTH=16, ITERATIONS=14, tolerance ±4 LSB)
REQ-029 Reset: assert rst mid-RUN -> out_valid=0, in_ready=1, outputs 0 while held; after release no out_valid without new accept.
REQ-030 x=16384,y=0,z=0 -> x_out≈26981, y_out≈0, out_valid exactly 14 edges after accept.
REQ-031 x=16384,y=0,z=8192 (pi/4) -> x_out≈19078, y_out≈19078, |z_out|<=4.
REQ-032 CORDIC_QUADRANT_EN defined: x=16384,y=0,z=-32768 (-pi) -> x_out≈-26981, y_out≈0; z=16384 -> x_out≈0, y_out≈26981.
REQ-033 Backpressure: out_ready low 10 cycles in DONE -> outputs stable, in_valid pulses ignored; out_ready high -> IDLE next edge, next request accepted.
REQ-034 Back-to-back random requests (|z|<=pi/2, |x|,|y|<=14000) vs float model within tolerance, with random out_ready stalls.
